// File: rtl/checkpoint_barrier.sv
// checkpoint_barrier
//
// Turns a checkpoint request into per-core interrupts, collects each core's
// acknowledgement over an Avalon-MM slave, pulses barrier_done once every
// core has acknowledged, and raises a sticky timeout when the window expires
// first. At most one further request is queued while a barrier is running.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   checkpoint_req    level request; its rising edge starts a barrier
//   avs_*             Avalon-MM slave, zero read latency, combinational readdata
//   core_irq          per-core checkpoint interrupt
//   barrier_done      one-cycle completion pulse
//   barrier_timeout   sticky timeout flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no barrier active; starts on a trigger or a queued request
// WAIT  | interrupts raised, collecting acks, timeout counter running
// DONE  | all cores acknowledged; completion pulse, epoch advances
// TMO   | window expired; interrupts dropped until software clears

module checkpoint_barrier #(
   parameter int NUM_CORES      = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 checkpoint_req,
   input  logic [7:0]           avs_address,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   input  logic                 avs_read,
   output logic [31:0]          avs_readdata,
   output logic [NUM_CORES-1:0] core_irq,
   output logic                 barrier_done,
   output logic                 barrier_timeout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_TMO  = 2'd3;

   localparam logic [15:0]          CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_CORES-1:0] ALL_ACK  = '1;

   logic [1:0]           state;
   logic                 req_q;
   logic [NUM_CORES-1:0] ack_vec;
   logic [15:0]          cnt;
   logic [15:0]          epoch;
   logic                 pending;
   logic                 overrun;
   logic                 timeout;

   logic                 wr_ctrl;
   logic                 wr_ack;
   logic                 clr_tmo;
   logic                 clr_ovr;
   logic                 trig;
   logic [NUM_CORES-1:0] ack_next;

   assign wr_ctrl  = avs_write && (avs_address == 8'd0);
   assign wr_ack   = avs_write && (avs_address == 8'd1);
   assign clr_tmo  = wr_ctrl && avs_writedata[0];
   assign clr_ovr  = wr_ctrl && avs_writedata[1];
   assign trig     = (checkpoint_req && !req_q) || (wr_ctrl && avs_writedata[2]);

   // Ack bits above NUM_CORES fall away by taking only the low slice.
   assign ack_next = wr_ack ? (ack_vec | avs_writedata[NUM_CORES-1:0]) : ack_vec;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         // Loading the live request during reset means a request already
         // high at release is not mistaken for a new edge.
         req_q    <= checkpoint_req;
         ack_vec  <= '0;
         cnt      <= '0;
         epoch    <= '0;
         pending  <= 1'b0;
         overrun  <= 1'b0;
         timeout  <= 1'b0;
         core_irq <= '0;
      end else begin
         req_q <= checkpoint_req;

         if (clr_ovr) begin
            overrun <= 1'b0;
         end

         // A request arriving mid-barrier is queued once; a second one is
         // dropped and recorded as an overrun.
         if (trig && (state != S_IDLE)) begin
            if (pending) begin
               overrun <= 1'b1;
            end else begin
               pending <= 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               if (trig || pending) begin
                  state    <= S_WAIT;
                  core_irq <= '1;
                  ack_vec  <= '0;
                  cnt      <= '0;
                  pending  <= 1'b0;
               end
            end
            S_WAIT: begin
               ack_vec  <= ack_next;
               core_irq <= ~ack_next;
               cnt      <= cnt + 16'd1;
               // Completion is checked first so a final ack on the last
               // allowed cycle still counts.
               if (ack_next == ALL_ACK) begin
                  state <= S_DONE;
               end else if (cnt == CNT_LAST) begin
                  state    <= S_TMO;
                  core_irq <= '0;
                  timeout  <= 1'b1;
               end
            end
            S_DONE: begin
               epoch <= epoch + 16'd1;
               state <= S_IDLE;
            end
            default: begin
               core_irq <= '0;
               if (clr_tmo) begin
                  timeout <= 1'b0;
                  state   <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign barrier_done    = (state == S_DONE);
   assign barrier_timeout = timeout;

   logic [7:0] ack_ext;

   always_comb begin
      ack_ext                  = '0;
      ack_ext[NUM_CORES-1:0]   = ack_vec;
      avs_readdata             = '0;
      case (avs_address)
         8'd0:    avs_readdata = {epoch, ack_ext, 3'b000, overrun, pending, timeout, state};
         8'd2:    avs_readdata = {16'd0, cnt};
         default: avs_readdata = '0;
      endcase
   end

   // Reads have no side effects and the mux is always live, so the strobe
   // and the upper write-data bits carry no information here.
   logic unused_ok;
   assign unused_ok = &{1'b0, avs_read, avs_writedata};

endmodule
